// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory responder.
// Optional read parity is enabled by defining MEM_PARITY_EN.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 2048;

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  function automatic logic parity_even(
    input logic [DEF_DATA_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/cpu_mem_bank.sv
// Word store: one write port, two registered read ports, forwarding.
// Per-word even parity is stored and checked when MEM_PARITY_EN is set.
module cpu_mem_bank
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              ren_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              parity_err
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_rng(
    input logic [ADDR_W-1:0] a
  );
    return {1'b0, a} < (ADDR_W+1)'(DEPTH);
  endfunction

  logic              we_ok;
  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] nxt_b;

  assign we_ok = we & in_rng(waddr);
  assign fwd_a = we_ok & (waddr == raddr_a);
  assign fwd_b = we_ok & (waddr == raddr_b);

  always_comb begin
    nxt_a = '0;
    nxt_b = '0;
    if (in_rng(raddr_a))
      nxt_a = fwd_a ? wdata
                    : mem[raddr_a[IW-1:0]];
    if (in_rng(raddr_b))
      nxt_b = fwd_b ? wdata
                    : mem[raddr_b[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (we_ok)
      mem[waddr[IW-1:0]] <= wdata;
  end

  // Outside run the read registers are held at zero.
  always_ff @(posedge clk) begin
    if (!resetn || !run) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (ren_a) rdata_a <= nxt_a;
      if (ren_b) rdata_b <= nxt_b;
    end
  end

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic bad_a;
  logic bad_b;

  always_ff @(posedge clk) begin
    if (we_ok)
      par_mem[waddr[IW-1:0]] <= parity_even(wdata);
  end

  assign bad_a = run & ren_a & in_rng(raddr_a) & ~fwd_a &
    (parity_even(mem[raddr_a[IW-1:0]])
      != par_mem[raddr_a[IW-1:0]]);
  assign bad_b = run & ren_b & in_rng(raddr_b) & ~fwd_b &
    (parity_even(mem[raddr_b[IW-1:0]])
      != par_mem[raddr_b[IW-1:0]]);

  always_ff @(posedge clk) begin
    if (!resetn)
      parity_err <= 1'b0;
    else if (bad_a | bad_b)
      parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder: boot loader FSM plus three-port CPU word store.
// MEM_PARITY_EN enables per-word parity checking in the bank.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              boot_valid,
  output logic              boot_ready,
  input  logic [DATA_W-1:0] boot_data,
  input  logic              boot_last,
  output logic              boot_done,
  output logic              cpu_resetn,
  input  logic              read_mem_ir,
  input  logic [ADDR_W-1:0] mem_radrs_ir,
  output logic [DATA_W-1:0] instruction_fetch,
  input  logic              read_mem_str,
  input  logic [ADDR_W-1:0] mem_radrs_ld,
  output logic [DATA_W-1:0] mem_store_data,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] mem_wadrs,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              parity_err
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] boot_cnt;
  logic              run_q;
  logic              run;
  logic              boot_acc;
  logic              boot_end;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;

  assign run        = (state == S_RUN);
  assign boot_ready = (state == S_BOOT) & resetn;
  assign boot_acc   = boot_valid & boot_ready;
  assign boot_end   = boot_acc &
    (boot_last | (boot_cnt == ADDR_W'(DEPTH-1)));

  always_comb begin
    state_n = state;
    unique case (state)
      S_BOOT:    if (boot_end) state_n = S_RELEASE;
      S_RELEASE: state_n = S_RUN;
      S_RUN:     state_n = S_RUN;
      default:   state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_BOOT;
      boot_cnt <= '0;
      run_q    <= 1'b0;
    end else begin
      state <= state_n;
      run_q <= run;
      if (boot_acc)
        boot_cnt <= boot_cnt + 1'b1;
    end
  end

  assign cpu_resetn = run_q;
  assign boot_done  = run_q;

  // Boot and CPU stores never overlap: boot_acc implies S_BOOT.
  assign bank_we    = boot_acc | (run & write_mem);
  assign bank_waddr = boot_acc ? boot_cnt  : mem_wadrs;
  assign bank_wdata = boot_acc ? boot_data : mem_wdata;

  cpu_mem_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk        (clk),
    .resetn     (resetn),
    .run        (run),
    .we         (bank_we),
    .waddr      (bank_waddr),
    .wdata      (bank_wdata),
    .ren_a      (read_mem_ir),
    .raddr_a    (mem_radrs_ir),
    .rdata_a    (instruction_fetch),
    .ren_b      (read_mem_str),
    .raddr_b    (mem_radrs_ld),
    .rdata_b    (mem_store_data),
    .parity_err (parity_err)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder against a word-array model.
module tb_cpu_mem_responder;

  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int DEP = 1024;

  logic          clk = 1'b0;
  logic          resetn;
  logic          boot_valid;
  logic          boot_ready;
  logic [DW-1:0] boot_data;
  logic          boot_last;
  logic          boot_done;
  logic          cpu_resetn;
  logic          read_mem_ir;
  logic [AW-1:0] mem_radrs_ir;
  logic [DW-1:0] instruction_fetch;
  logic          read_mem_str;
  logic [AW-1:0] mem_radrs_ld;
  logic [DW-1:0] mem_store_data;
  logic          write_mem;
  logic [AW-1:0] mem_wadrs;
  logic [DW-1:0] mem_wdata;
  logic          parity_err;

  cpu_mem_responder #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEP)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .boot_valid        (boot_valid),
    .boot_ready        (boot_ready),
    .boot_data         (boot_data),
    .boot_last         (boot_last),
    .boot_done         (boot_done),
    .cpu_resetn        (cpu_resetn),
    .read_mem_ir       (read_mem_ir),
    .mem_radrs_ir      (mem_radrs_ir),
    .instruction_fetch (instruction_fetch),
    .read_mem_str      (read_mem_str),
    .mem_radrs_ld      (mem_radrs_ld),
    .mem_store_data    (mem_store_data),
    .write_mem         (write_mem),
    .mem_wadrs         (mem_wadrs),
    .mem_wdata         (mem_wdata),
    .parity_err        (parity_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model [int];
  bit            mrun;
  logic [DW-1:0] q_ir[$];
  logic [DW-1:0] q_ld[$];

  task automatic chk(string name, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(
    int a, bit we, int wa, logic [DW-1:0] wd);
    if (!mrun || a >= DEP) return '0;
    if (we && wa < DEP && wa == a) return wd;
    if (model.exists(a)) return model[a];
    return '0;
  endfunction

  task automatic op(bit ie, int ia, bit le, int la,
                    bit we, int wa, logic [DW-1:0] wd);
    @(negedge clk);
    read_mem_ir  = ie;
    mem_radrs_ir = AW'(ia);
    read_mem_str = le;
    mem_radrs_ld = AW'(la);
    write_mem    = we;
    mem_wadrs    = AW'(wa);
    mem_wdata    = wd;
    if (ie) q_ir.push_back(ref_rd(ia, we, wa, wd));
    if (le) q_ld.push_back(ref_rd(la, we, wa, wd));
    if (mrun && we && wa < DEP) model[wa] = wd;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      read_mem_ir  = 1'b0;
      read_mem_str = 1'b0;
      write_mem    = 1'b0;
      boot_valid   = 1'b0;
      boot_last    = 1'b0;
    end
  endtask

  task automatic boot(input logic [DW-1:0] w[$], bit last_fin,
                      bit stall);
    int bc = 0;
    foreach (w[i]) begin
      if (stall) idle($urandom_range(1, 3));
      @(negedge clk);
      boot_valid = 1'b1;
      boot_data  = w[i];
      boot_last  = last_fin && (i == w.size() - 1);
      chk("cpu_resetn_boot", {31'b0, cpu_resetn}, 0);
      for (int g = 0; g < 20 && !boot_ready; g++)
        @(negedge clk);
      chk("boot_ready", {31'b0, boot_ready}, 1);
      @(posedge clk);
      model[bc] = w[i];
      bc++;
    end
    @(negedge clk);
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask

  task automatic boot_done_seq();
    chk("done_release", {31'b0, boot_done}, 0);
    @(negedge clk);
    chk("done_run0", {31'b0, boot_done}, 0);
    chk("cpurst_run0", {31'b0, cpu_resetn}, 0);
    @(negedge clk);
    chk("done_run1", {31'b0, boot_done}, 1);
    chk("cpurst_run1", {31'b0, cpu_resetn}, 1);
    chk("ready_run", {31'b0, boot_ready}, 0);
    mrun = 1'b1;
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    idle(0);
    resetn = 1'b0;
    mrun   = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_cpu_resetn", {31'b0, cpu_resetn}, 0);
    chk("rst_boot_done", {31'b0, boot_done}, 0);
    chk("rst_boot_ready", {31'b0, boot_ready}, 0);
    chk("rst_parity", {31'b0, parity_err}, 0);
    resetn = 1'b1;
  endtask

  logic [DW-1:0] last_ir = '0;
  logic [DW-1:0] last_ld = '0;

  initial begin
    forever begin
      bit ie, le, rs;
      @(posedge clk);
      ie = read_mem_ir;
      le = read_mem_str;
      rs = resetn;
      #1;
      if (!rs) begin
        last_ir = '0;
        last_ld = '0;
      end else begin
        if (ie) begin
          if (q_ir.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_ir actual=empty required=entry");
          end else last_ir = q_ir.pop_front();
        end
        if (le) begin
          if (q_ld.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_ld actual=empty required=entry");
          end else last_ld = q_ld.pop_front();
        end
      end
      chk(ie ? "ir_read" : "ir_hold", instruction_fetch, last_ir);
      chk(le ? "ld_read" : "ld_hold", mem_store_data, last_ld);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] img3[$];
    logic [DW-1:0] imga[$];
    logic [DW-1:0] imgb[$];
    resetn = 1'b0; mrun = 1'b0;
    boot_valid = 0; boot_data = '0; boot_last = 0;
    read_mem_ir = 0; mem_radrs_ir = '0;
    read_mem_str = 0; mem_radrs_ld = '0;
    write_mem = 0; mem_wadrs = '0; mem_wdata = '0;
    do_reset(3);

    op(1, 0, 1, 1, 1, 4, 32'h1234_5678);
    idle(1);
    img3 = '{32'hE000_0005, 32'h8000_0000, 32'hA000_0000};
    boot(img3, 1'b1, 1'b0);
    boot_done_seq();
    for (int a = 0; a < 3; a++) op(1, a, 0, 0, 0, 0, '0);
    idle(2);

    op(0, 0, 1, 16, 1, 16, 32'hDEAD_BEEF);
    op(0, 0, 1, 16, 0, 0, '0);
    op(0, 0, 0, 0, 1, 5, 32'h5555_AAAA);
    op(1, 5, 1, 5, 0, 0, '0);
    idle(3);
    op(0, 0, 0, 0, 1, 'h3FF, 32'h0BAD_F00D);
    op(1, 'h7FF, 1, 'h3FF, 1, 'h7FF, 32'hFFFF_FFFF);
    op(1, 'h3FF, 1, 'h7FF, 0, 0, '0);
    op(1, 'h400, 0, 0, 1, 'h400, 32'h1111_1111);
    op(1, 0, 0, 0, 0, 0, '0);
    idle(2);

    do_reset(1);
    imga = '{32'hAAAA_0000, 32'hAAAA_0001,
             32'hAAAA_0002, 32'hAAAA_0003};
    imgb = '{32'hBBBB_0000, 32'hBBBB_0001,
             32'hBBBB_0002, 32'hBBBB_0003};
    imga = imga[0:1];
    boot(imga, 1'b0, 1'b1);
    do_reset(2);
    boot(imgb, 1'b1, 1'b1);
    boot_done_seq();
    for (int a = 0; a < 4; a++) op(1, a, 1, 3 - a, 0, 0, '0);
    chk("boot_stall_cnt", model[3], 32'hBBBB_0003);

    for (int a = 0; a < 32; a++) op(0, 0, 0, 0, 1, a, $urandom);
    for (int n = 0; n < 300; n++) begin
      int ia, la, wa;
      ia = ($urandom_range(0, 7) == 0) ? $urandom_range(DEP, 2047)
                                       : $urandom_range(0, 31);
      la = ($urandom_range(0, 7) == 0) ? $urandom_range(DEP, 2047)
                                       : $urandom_range(0, 31);
      wa = ($urandom_range(0, 7) == 0) ? $urandom_range(DEP, 2047)
                                       : $urandom_range(0, 31);
      op($urandom_range(0, 1) == 1, ia, $urandom_range(0, 1) == 1, la,
         $urandom_range(0, 1) == 1, wa, $urandom);
    end
    idle(2);

`ifdef MEM_PARITY_EN
    dut.u_bank.par_mem[7] = ~dut.u_bank.par_mem[7];
    op(1, 7, 0, 0, 0, 0, '0);
    idle(1);
    chk("parity_set", {31'b0, parity_err}, 1);
    idle(4);
    chk("parity_sticky", {31'b0, parity_err}, 1);
    do_reset(1);
`else
    chk("parity_tied", {31'b0, parity_err}, 0);
`endif
    idle(2);
    chk("sb_drain", q_ir.size() + q_ld.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
